// File: rtl/uart_tx_if.sv
// Handshake, configuration and serial-line bundle between a UART transmitter and its
// producer, including the enable/tick pair shared with the baud-rate generator.
interface uart_tx_if #(
    parameter int DATA_BITS = 8
);
    logic                 baud_tick;
    logic                 tx_start;
    logic [DATA_BITS-1:0] tx_data;
    logic                 parity_en;
    logic                 parity_odd;
    logic                 two_stop;
    logic                 baud_en;
    logic                 tx;
    logic                 tx_busy;
    logic                 tx_done;

    modport master (
        output baud_tick, tx_start, tx_data, parity_en, parity_odd, two_stop,
        input  baud_en, tx, tx_busy, tx_done
    );

    modport slave (
        input  baud_tick, tx_start, tx_data, parity_en, parity_odd, two_stop,
        output baud_en, tx, tx_busy, tx_done
    );
endinterface

// File: rtl/uart_tx.sv
// UART serial transmitter: start bit, DATA_BITS data bits LSB-first, optional parity,
// one or two stop bits. Every bit period is ended by a baud_tick from the baud generator.
module uart_tx #(
    parameter int DATA_BITS = 8
) (
    input  logic     clk,
    input  logic     rst,
    uart_tx_if.slave bus
);
    localparam int               CNT_W    = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP1  = 3'd4,
        STOP2  = 3'd5
    } state_t;

    state_t               state_r,     state_s;
    logic [DATA_BITS-1:0] shift_r,     shift_s;
    logic [CNT_W-1:0]     bit_cnt_r,   bit_cnt_s;
    logic                 parity_r,    parity_s;
    logic                 parity_en_r, parity_en_s;
    logic                 two_stop_r,  two_stop_s;
    logic                 tx_r,        tx_s;
    logic                 busy_r,      busy_s;
    logic                 done_r,      done_s;
    logic                 baud_en_r,   baud_en_s;

    function automatic logic calc_parity(input logic [DATA_BITS-1:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

    // State, datapath and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            shift_r     <= '0;
            bit_cnt_r   <= '0;
            parity_r    <= 1'b0;
            parity_en_r <= 1'b0;
            two_stop_r  <= 1'b0;
            tx_r        <= 1'b1;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            baud_en_r   <= 1'b0;
        end else begin
            state_r     <= state_s;
            shift_r     <= shift_s;
            bit_cnt_r   <= bit_cnt_s;
            parity_r    <= parity_s;
            parity_en_r <= parity_en_s;
            two_stop_r  <= two_stop_s;
            tx_r        <= tx_s;
            busy_r      <= busy_s;
            done_r      <= done_s;
            baud_en_r   <= baud_en_s;
        end
    end

    // Next-state and next-output decode; the line value is computed one edge ahead
    always_comb begin
        state_s     = state_r;
        shift_s     = shift_r;
        bit_cnt_s   = bit_cnt_r;
        parity_s    = parity_r;
        parity_en_s = parity_en_r;
        two_stop_s  = two_stop_r;
        tx_s        = tx_r;
        busy_s      = busy_r;
        done_s      = 1'b0;
        baud_en_s   = baud_en_r;

        case (state_r)
            IDLE: begin
                tx_s      = 1'b1;
                busy_s    = 1'b0;
                baud_en_s = 1'b0;
                if (bus.tx_start) begin
                    shift_s     = bus.tx_data;
                    parity_s    = calc_parity(bus.tx_data, bus.parity_odd);
                    parity_en_s = bus.parity_en;
                    two_stop_s  = bus.two_stop;
                    state_s     = START;
                    tx_s        = 1'b0;
                    busy_s      = 1'b1;
                    baud_en_s   = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            START: begin
                if (bus.baud_tick) begin
                    state_s   = DATA;
                    tx_s      = shift_r[0];
                    shift_s   = {1'b0, shift_r[DATA_BITS-1:1]};
                    bit_cnt_s = '0;
                end else begin
                    tx_s = 1'b0;
                end
            end
            DATA: begin
                // shift_r[0] always holds the bit that goes out after the current one
                if (bus.baud_tick) begin
                    if (bit_cnt_r != LAST_BIT) begin
                        bit_cnt_s = bit_cnt_r + CNT_W'(1);
                        tx_s      = shift_r[0];
                        shift_s   = {1'b0, shift_r[DATA_BITS-1:1]};
                    end else if (parity_en_r) begin
                        state_s = PARITY;
                        tx_s    = parity_r;
                    end else begin
                        state_s = STOP1;
                        tx_s    = 1'b1;
                    end
                end else begin
                    state_s = DATA;
                end
            end
            PARITY: begin
                if (bus.baud_tick) begin
                    state_s = STOP1;
                    tx_s    = 1'b1;
                end else begin
                    tx_s = parity_r;
                end
            end
            STOP1: begin
                tx_s = 1'b1;
                if (bus.baud_tick) begin
                    if (two_stop_r) begin
                        state_s = STOP2;
                    end else begin
                        state_s   = IDLE;
                        busy_s    = 1'b0;
                        baud_en_s = 1'b0;
                        done_s    = 1'b1;
                    end
                end else begin
                    state_s = STOP1;
                end
            end
            STOP2: begin
                tx_s = 1'b1;
                if (bus.baud_tick) begin
                    state_s   = IDLE;
                    busy_s    = 1'b0;
                    baud_en_s = 1'b0;
                    done_s    = 1'b1;
                end else begin
                    state_s = STOP2;
                end
            end
            default: begin
                state_s   = IDLE;
                tx_s      = 1'b1;
                busy_s    = 1'b0;
                baud_en_s = 1'b0;
            end
        endcase
    end

    assign bus.tx      = tx_r;
    assign bus.tx_busy = busy_r;
    assign bus.tx_done = done_r;
    assign bus.baud_en = baud_en_r;
endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: directed frames plus randomized traffic compared
// cycle by cycle against a frame-list reference model.
module tb_uart_tx;
    localparam int DATA_BITS = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    uart_tx_if #(.DATA_BITS(DATA_BITS)) bus ();
    uart_tx #(.DATA_BITS(DATA_BITS)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    int n_checks = 0;
    int n_fail   = 0;

    // reference model: the frame as a list of line levels, one per tick interval
    bit m_busy = 1'b0;
    bit m_done = 1'b0;
    bit m_tx   = 1'b1;
    int m_idx  = 0;
    bit m_frame[$];

    int tick_div  = 4;
    int tick_cnt  = 0;
    bit tick_rand = 1'b0;
    bit cap_bits[$];
    int done_cnt  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void build_frame(input logic [7:0] d, input bit pe, input bit po, input bit ts);
        int ones;
        ones = 0;
        m_frame.delete();
        m_frame.push_back(1'b0);
        for (int i = 0; i < DATA_BITS; i++) begin
            m_frame.push_back(d[i]);
            ones += int'(d[i]);
        end
        if (pe) m_frame.push_back(((ones % 2) == 1) != po);
        m_frame.push_back(1'b1);
        if (ts) m_frame.push_back(1'b1);
    endfunction

    function automatic logic [15:0] cap_vec();
        logic [15:0] v;
        v = '0;
        for (int i = 0; i < cap_bits.size() && i < 16; i++) v[i] = cap_bits[i];
        return v;
    endfunction

    // one clock: drive tick, advance the model, let the edge pass, compare at negedge
    task automatic step();
        if (tick_rand) begin
            bus.baud_tick = ($urandom_range(0, 3) == 0);
        end else begin
            bus.baud_tick = (tick_cnt == tick_div - 1);
            tick_cnt = (tick_cnt == tick_div - 1) ? 0 : tick_cnt + 1;
        end
        if (bus.baud_tick && m_busy) cap_bits.push_back(bus.tx);
        m_done = 1'b0;
        if (!m_busy) begin
            if (bus.tx_start) begin
                build_frame(bus.tx_data, bus.parity_en, bus.parity_odd, bus.two_stop);
                m_busy = 1'b1;
                m_idx  = 0;
                m_tx   = m_frame[0];
            end else begin
                m_tx = 1'b1;
            end
        end else if (bus.baud_tick) begin
            m_idx++;
            if (m_idx == m_frame.size()) begin
                m_busy = 1'b0;
                m_done = 1'b1;
                m_tx   = 1'b1;
            end else begin
                m_tx = m_frame[m_idx];
            end
        end
        @(posedge clk);
        @(negedge clk);
        check("tx", bus.tx, m_tx);
        check("tx_busy", bus.tx_busy, m_busy);
        check("tx_done", bus.tx_done, m_done);
        check("baud_en", bus.baud_en, m_busy);
        if (bus.tx_done) done_cnt++;
    endtask

    task automatic send(input logic [7:0] d, input bit pe, input bit po, input bit ts,
                        input bit hold, input int poke);
        int budget;
        budget = tick_rand ? 400 : 14 * tick_div + 10;
        bus.tx_data    = d;
        bus.parity_en  = pe;
        bus.parity_odd = po;
        bus.two_stop   = ts;
        bus.tx_start   = 1'b1;
        cap_bits.delete();
        done_cnt = 0;
        step();
        if (!hold) bus.tx_start = 1'b0;
        bus.tx_data    = 8'($urandom);
        bus.parity_en  = 1'($urandom_range(0, 1));
        bus.parity_odd = 1'($urandom_range(0, 1));
        bus.two_stop   = 1'($urandom_range(0, 1));
        for (int i = 0; i < budget && m_busy; i++) begin
            if (poke > 0 && i == poke) begin
                bus.tx_start = 1'b1;
                bus.tx_data  = 8'h00;
            end else if (poke > 0 && i == poke + 1) begin
                bus.tx_start = 1'b0;
            end
            step();
        end
        check("frame_end_busy", bus.tx_busy, 1'b0);
        check("done_pulses", done_cnt, 1);
    endtask

    initial begin
        rst            = 1'b1;
        bus.baud_tick  = 1'b0;
        bus.tx_start   = 1'b0;
        bus.tx_data    = 8'h00;
        bus.parity_en  = 1'b0;
        bus.parity_odd = 1'b0;
        bus.two_stop   = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("reset_tx", bus.tx, 1'b1);
        check("reset_busy", bus.tx_busy, 1'b0);
        check("reset_done", bus.tx_done, 1'b0);
        check("reset_baud_en", bus.baud_en, 1'b0);
        rst = 1'b0;

        // ticks while idle must be ignored
        tick_div = 2;
        repeat (10) step();

        // 8N1 A5
        tick_div = 130;
        tick_cnt = 0;
        send(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        check("8n1_ticks", cap_bits.size(), 10);
        check("8n1_bits", cap_vec(), 16'b0000_0011_0100_1010);
        repeat (3) step();

        // 8E1 / 8O1 with 07
        tick_div = 4;
        send(8'h07, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        check("8e1_ticks", cap_bits.size(), 11);
        check("8e1_parity", cap_bits[9], 1'b1);
        send(8'h07, 1'b1, 1'b1, 1'b0, 1'b0, 0);
        check("8o1_ticks", cap_bits.size(), 11);
        check("8o1_parity", cap_bits[9], 1'b0);

        // 8N2 FF
        send(8'hFF, 1'b0, 1'b0, 1'b1, 1'b0, 0);
        check("8n2_ticks", cap_bits.size(), 11);
        check("8n2_bits", cap_vec(), 16'b0000_0111_1111_1110);

        // start request during DATA is ignored
        send(8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 12);
        check("busy_ignore_bits", cap_vec(), 16'b0000_0010_1011_0100);

        // back-to-back: request held through the done cycle
        tick_div = 3;
        send(8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 0);
        step();
        check("b2b_start_bit", bus.tx, 1'b0);
        check("b2b_busy", bus.tx_busy, 1'b1);
        bus.tx_start = 1'b0;
        for (int i = 0; i < 60 && m_busy; i++) step();
        check("b2b_end_busy", bus.tx_busy, 1'b0);

        // reset in the middle of a frame
        bus.tx_data  = 8'hC3;
        bus.tx_start = 1'b1;
        step();
        bus.tx_start = 1'b0;
        repeat (10) step();
        check("pre_reset_busy", bus.tx_busy, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("midrst_tx", bus.tx, 1'b1);
        check("midrst_busy", bus.tx_busy, 1'b0);
        check("midrst_baud_en", bus.baud_en, 1'b0);
        m_busy = 1'b0;
        m_tx   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midrst_no_done", bus.tx_done, 1'b0);
        rst = 1'b0;
        repeat (5) step();

        // randomized frames with random tick spacing and random back-to-back requests
        tick_rand = 1'b1;
        for (int n = 0; n < 30; n++) begin
            send(8'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
        end
        bus.tx_start = 1'b0;
        for (int i = 0; i < 400 && m_busy; i++) step();
        repeat (5) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
